aq_func_launcher: RTL and testbench

Local-bus initiator that drives one function-control register block on the LOCAL_* bus from a simple command/response handshake. It sits between a host-side sequencer, such as a DMA descriptor walker or a test controller, and the function-control slave. Per command it performs four steps: write the argument register, pulse START, poll STATUS until DONE or until a poll budget runs out, and report the outcome. It is the bus-master end of the slave's LOCAL_CS/RNW/ACK protocol.

---
 rtl/aq_local_bus_pkg.sv | 25 ++
 rtl/aq_local_bus_master.sv | 54 +++++
 rtl/aq_func_launcher.sv | 160 ++++++++++++++++
 tb/tb_aq_func_launcher.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_local_bus_pkg.sv
// Shared constants and types for the function-control local-bus initiator.
// Register offsets, STATUS bit positions, launcher state encoding and response codes.
package aq_local_bus_pkg;

    localparam logic [31:0] A_FUNC_START   = 32'h0000_0000;
    localparam logic [31:0] A_FUNC_STATUS  = 32'h0000_0004;
    localparam logic [31:0] A_FUNC_ARGS_00 = 32'h0000_0010;

    localparam int unsigned STAT_DONE_BIT  = 0;
    localparam int unsigned STAT_READY_BIT = 1;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT = 2'd1;

    typedef enum logic [2:0] {
        StIdle,
        StWrArg,
        StSep,
        StWrStart,
        StGap,
        StRdStat,
        StResp
    } launch_state_e;

endpackage

// File: rtl/aq_local_bus_master.sv
// Single-transaction LOCAL_* bus engine: holds CS and the request fields until a
// CS-qualified ACK, then drops CS for at least one cycle before accepting another request.
module aq_local_bus_master (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_rnw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        LOCAL_CS,
    output logic        LOCAL_RNW,
    input  logic        LOCAL_ACK,
    output logic [31:0] LOCAL_ADDR,
    output logic [3:0]  LOCAL_BE,
    output logic [31:0] LOCAL_WDATA,
    input  logic [31:0] LOCAL_RDATA
);

    logic        cs_q;
    logic        rnw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // A request is only taken while CS is low, so CS always spends at least the
    // cycle after an ACK deasserted; addr/data are left untouched after ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_q    <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cs_q) begin
            if (LOCAL_ACK) begin
                cs_q <= 1'b0;
            end
        end else if (req_valid) begin
            cs_q    <= 1'b1;
            rnw_q   <= req_rnw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign done        = cs_q & LOCAL_ACK;
    assign rdata       = LOCAL_RDATA;
    assign LOCAL_CS    = cs_q;
    assign LOCAL_RNW   = rnw_q;
    assign LOCAL_ADDR  = addr_q;
    assign LOCAL_BE    = cs_q ? 4'hF : 4'h0;
    assign LOCAL_WDATA = wdata_q;

endmodule

// File: rtl/aq_func_launcher.sv
// Command-driven launcher: writes ARGS_00, pulses START, polls STATUS for DONE with a
// bounded poll budget, then reports the outcome on a held response handshake.
module aq_func_launcher
    import aq_local_bus_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_BASE,
    input  logic [31:0] CMD_ARG,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [1:0]  RSP_STATUS,
    output logic [15:0] RSP_POLLS,
    output logic        BUSY,
    output logic        LOCAL_CS,
    output logic        LOCAL_RNW,
    input  logic        LOCAL_ACK,
    output logic [31:0] LOCAL_ADDR,
    output logic [3:0]  LOCAL_BE,
    output logic [31:0] LOCAL_WDATA,
    input  logic [31:0] LOCAL_RDATA
);

    localparam int unsigned GapCycles = (POLL_GAP == 0) ? 1 : POLL_GAP;
    localparam logic [7:0]  GapLast   = 8'(GapCycles - 1);
    localparam logic [15:0] PollLimit = 16'(MAX_POLLS);

    launch_state_e state_q;
    logic [31:0]   base_q;
    logic [15:0]   poll_cnt_q;
    logic [7:0]    gap_cnt_q;
    logic [1:0]    rsp_status_q;

    logic          req_valid;
    logic          req_rnw;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          done;
    logic [31:0]   rdata;
    logic [15:0]   poll_next;
    logic          unused_rdata;

    // Requests are issued in the cycle before each bus state so CS rises on entry.
    always_comb begin
        req_valid = 1'b0;
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    req_valid = 1'b1;
                    req_addr  = CMD_BASE | A_FUNC_ARGS_00;
                    req_wdata = CMD_ARG;
                end
            end
            StSep: begin
                req_valid = 1'b1;
                req_addr  = base_q | A_FUNC_START;
                req_wdata = 32'h0000_0001;
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    req_valid = 1'b1;
                    req_rnw   = 1'b1;
                    req_addr  = base_q | A_FUNC_STATUS;
                end
            end
            default: ;
        endcase
    end

    assign poll_next = poll_cnt_q + 16'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            base_q       <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            rsp_status_q <= RSP_OK;
        end else begin
            case (state_q)
                StIdle: begin
                    if (CMD_VALID) begin
                        base_q     <= CMD_BASE;
                        poll_cnt_q <= '0;
                        state_q    <= StWrArg;
                    end
                end
                StWrArg: begin
                    if (done) state_q <= StSep;
                end
                StSep: state_q <= StWrStart;
                StWrStart: begin
                    if (done) begin
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) state_q <= StRdStat;
                    else gap_cnt_q <= gap_cnt_q + 8'd1;
                end
                StRdStat: begin
                    if (done) begin
                        poll_cnt_q <= poll_next;
                        if (rdata[STAT_DONE_BIT]) begin
                            rsp_status_q <= RSP_OK;
                            state_q      <= StResp;
                        end else if (poll_next == PollLimit) begin
                            rsp_status_q <= RSP_TIMEOUT;
                            state_q      <= StResp;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end
                end
                StResp: begin
                    if (RSP_READY) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // READY and the remaining STATUS bits carry no decision here.
    assign unused_rdata = ^{rdata[31:STAT_READY_BIT + 1], rdata[STAT_READY_BIT]};

    assign CMD_READY  = (state_q == StIdle);
    assign BUSY       = (state_q != StIdle);
    assign RSP_VALID  = (state_q == StResp);
    assign RSP_STATUS = rsp_status_q;
    assign RSP_POLLS  = poll_cnt_q;

    aq_local_bus_master u_bus_master (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_rnw     (req_rnw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .done        (done),
        .rdata       (rdata),
        .LOCAL_CS    (LOCAL_CS),
        .LOCAL_RNW   (LOCAL_RNW),
        .LOCAL_ACK   (LOCAL_ACK),
        .LOCAL_ADDR  (LOCAL_ADDR),
        .LOCAL_BE    (LOCAL_BE),
        .LOCAL_WDATA (LOCAL_WDATA),
        .LOCAL_RDATA (LOCAL_RDATA)
    );

endmodule

// File: tb/tb_aq_func_launcher.sv
// Directed bench for aq_func_launcher: two instances (POLL_GAP=4/MAX_POLLS=3 and
// POLL_GAP=2/MAX_POLLS=1000), each with a configurable wait-state slave and bus monitor.
module tb_aq_func_launcher;

    logic clk;
    logic rst;
    logic clr_mon;

    logic        cmd_valid  [2];
    logic [31:0] cmd_base   [2];
    logic [31:0] cmd_arg    [2];
    logic        rsp_ready  [2];
    logic        cmd_ready  [2];
    logic        rsp_valid  [2];
    logic [1:0]  rsp_status [2];
    logic [15:0] rsp_polls  [2];
    logic        busy       [2];
    logic        cs         [2];
    logic        rnw        [2];
    logic [31:0] addr       [2];
    logic [3:0]  be         [2];
    logic [31:0] wdata      [2];
    logic        ack        [2];
    logic [31:0] rdata      [2];

    logic [3:0]  wait_cfg   [2];
    int          done_after [2];
    logic        stray_en   [2];

    int checks   = 0;
    int failures = 0;
    int cyc;
    int bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int unsigned Gap  = (gi == 0) ? 4 : 2;
        localparam int unsigned MaxP = (gi == 0) ? 3 : 1000;

        logic [3:0]  cnt;
        logic        stray_q;
        logic        real_ack;
        logic        done_bit;
        logic        cs_d;
        logic        rnw_d;
        logic [31:0] addr_d;
        logic [31:0] wdata_d;
        int          rd_cnt  = 0;
        int          wr_cnt  = 0;
        int          cs_rise = 0;
        int          viol    = 0;
        int          gap_min = 1000;
        int          gap_max = 0;
        int          low_run = 0;
        logic [31:0] wr_addr [4];
        logic [31:0] wr_data [4];
        logic [31:0] rd_addr_last;

        aq_func_launcher #(
            .POLL_GAP  (Gap),
            .MAX_POLLS (MaxP)
        ) u_dut (
            .CLK         (clk),
            .RST         (rst),
            .CMD_VALID   (cmd_valid[gi]),
            .CMD_READY   (cmd_ready[gi]),
            .CMD_BASE    (cmd_base[gi]),
            .CMD_ARG     (cmd_arg[gi]),
            .RSP_VALID   (rsp_valid[gi]),
            .RSP_READY   (rsp_ready[gi]),
            .RSP_STATUS  (rsp_status[gi]),
            .RSP_POLLS   (rsp_polls[gi]),
            .BUSY        (busy[gi]),
            .LOCAL_CS    (cs[gi]),
            .LOCAL_RNW   (rnw[gi]),
            .LOCAL_ACK   (ack[gi]),
            .LOCAL_ADDR  (addr[gi]),
            .LOCAL_BE    (be[gi]),
            .LOCAL_WDATA (wdata[gi]),
            .LOCAL_RDATA (rdata[gi])
        );

        // Writes ack combinationally after wait_cfg cycles, reads one cycle later.
        assign real_ack = cs[gi] && (cnt == (rnw[gi] ? wait_cfg[gi] + 4'd1 : wait_cfg[gi]));
        assign ack[gi]  = real_ack | stray_q;
        assign done_bit = (done_after[gi] != 0) && (rd_cnt + 1 >= done_after[gi]);
        assign rdata[gi] = {16'hA5A4, 14'h0, 1'b1, done_bit};

        always @(posedge clk) begin
            if (!cs[gi] || real_ack) cnt <= 4'd0;
            else cnt <= cnt + 4'd1;
            stray_q <= real_ack && stray_en[gi];
            cs_d    <= cs[gi];
            rnw_d   <= rnw[gi];
            addr_d  <= addr[gi];
            wdata_d <= wdata[gi];
            low_run <= cs[gi] ? 0 : low_run + 1;
            if (clr_mon) begin
                rd_cnt  <= 0;
                wr_cnt  <= 0;
                cs_rise <= 0;
                viol    <= 0;
                gap_min <= 1000;
                gap_max <= 0;
            end else begin
                if (cs[gi] && !cs_d) begin
                    cs_rise <= cs_rise + 1;
                    if (rnw[gi] && rd_cnt > 0) begin
                        if (low_run < gap_min) gap_min <= low_run;
                        if (low_run > gap_max) gap_max <= low_run;
                    end
                end
                if (cs[gi] && cs_d && (addr[gi] != addr_d || rnw[gi] != rnw_d
                                       || wdata[gi] != wdata_d)) viol <= viol + 1;
                if (cs[gi] && be[gi] != 4'hF) viol <= viol + 1;
                if (real_ack) begin
                    if (rnw[gi]) begin
                        rd_cnt       <= rd_cnt + 1;
                        rd_addr_last <= addr[gi];
                    end else begin
                        if (wr_cnt < 4) begin
                            wr_addr[wr_cnt] <= addr[gi];
                            wr_data[wr_cnt] <= wdata[gi];
                        end
                        wr_cnt <= wr_cnt + 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        step();
        clr_mon = 1'b0;
    endtask

    task automatic issue(input int i, input logic [31:0] base, input logic [31:0] arg);
        cmd_valid[i] = 1'b1;
        cmd_base[i]  = base;
        cmd_arg[i]   = arg;
        step();
        cmd_valid[i] = 1'b0;
    endtask

    // Returns the cycle number (cycle 1 follows the accepting edge) of first RSP_VALID.
    task automatic wait_rsp(input int i, output int c);
        c = 1;
        while (rsp_valid[i] !== 1'b1 && c < 200) begin
            step();
            c++;
        end
    endtask

    task automatic accept(input int i);
        rsp_ready[i] = 1'b1;
        step();
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        clr_mon = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i]  = 1'b0;
            cmd_base[i]   = '0;
            cmd_arg[i]    = '0;
            rsp_ready[i]  = 1'b0;
            wait_cfg[i]   = 4'd0;
            done_after[i] = 1;
            stray_en[i]   = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        for (int i = 0; i < 2; i++) begin
            check("rst_cmd_ready", 32'(cmd_ready[i]), 1);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 0);
            check("rst_cs", 32'(cs[i]), 0);
        end
        check("rst_be", 32'(be[0]), 0);
        check("rst_addr", addr[0], 0);
        check("rst_rsp_status", 32'(rsp_status[0]), 0);
        check("rst_rsp_polls", 32'(rsp_polls[0]), 0);

        // Zero-wait slave, DONE on first poll, POLL_GAP=4
        clear_mon();
        issue(0, 32'h4000_0000, 32'hDEAD_BEEF);
        wait_rsp(0, cyc);
        check("t1_rsp_cycle", cyc, 10);
        check("t1_status", 32'(rsp_status[0]), 0);
        check("t1_polls", 32'(rsp_polls[0]), 1);
        check("t1_cmd_ready_in_resp", 32'(cmd_ready[0]), 0);
        check("t1_wr_cnt", g_inst[0].wr_cnt, 2);
        check("t1_wr0_addr", g_inst[0].wr_addr[0], 32'h4000_0010);
        check("t1_wr0_data", g_inst[0].wr_data[0], 32'hDEAD_BEEF);
        check("t1_wr1_addr", g_inst[0].wr_addr[1], 32'h4000_0000);
        check("t1_wr1_data", g_inst[0].wr_data[1], 32'h0000_0001);
        check("t1_rd_cnt", g_inst[0].rd_cnt, 1);
        check("t1_rd_addr", g_inst[0].rd_addr_last, 32'h4000_0004);
        check("t1_bus_viol", g_inst[0].viol, 0);
        accept(0);
        check("t1_rsp_dropped", 32'(rsp_valid[0]), 0);
        check("t1_cmd_ready_back", 32'(cmd_ready[0]), 1);

        // DONE after the fifth read, POLL_GAP=2
        done_after[1] = 5;
        clear_mon();
        issue(1, 32'h5000_0100, 32'h1234_5678);
        wait_rsp(1, cyc);
        check("t2_rsp_cycle", cyc, 24);
        check("t2_status", 32'(rsp_status[1]), 0);
        check("t2_polls", 32'(rsp_polls[1]), 5);
        check("t2_rd_cnt", g_inst[1].rd_cnt, 5);
        check("t2_gap_min", g_inst[1].gap_min, 2);
        check("t2_gap_max", g_inst[1].gap_max, 2);
        check("t2_rd_addr", g_inst[1].rd_addr_last, 32'h5000_0104);
        accept(1);

        // DONE never set, MAX_POLLS=3; response then held for 20 cycles
        done_after[0] = 0;
        clear_mon();
        issue(0, 32'h4000_0000, 32'h0000_00AA);
        wait_rsp(0, cyc);
        check("t3_rsp_cycle", cyc, 22);
        check("t3_status", 32'(rsp_status[0]), 1);
        check("t3_polls", 32'(rsp_polls[0]), 3);
        check("t3_rd_cnt", g_inst[0].rd_cnt, 3);
        bad = 0;
        repeat (20) begin
            step();
            if (!(rsp_valid[0] === 1'b1 && rsp_status[0] === 2'd1 && rsp_polls[0] === 16'd3
                  && cmd_ready[0] === 1'b0)) bad++;
        end
        check("t5_hold_stable", bad, 0);
        check("t3_no_fourth_cs", g_inst[0].cs_rise, 5);
        accept(0);
        check("t5_rsp_dropped", 32'(rsp_valid[0]), 0);
        check("t5_cmd_ready", 32'(cmd_ready[0]), 1);

        // Three wait states before every ACK plus a trailing ACK with CS low
        wait_cfg[0]   = 4'd3;
        stray_en[0]   = 1'b1;
        done_after[0] = 1;
        clear_mon();
        issue(0, 32'h4000_0000, 32'h0BAD_F00D);
        wait_rsp(0, cyc);
        check("t4_rsp_cycle", cyc, 19);
        check("t4_bus_viol", g_inst[0].viol, 0);
        check("t4_wr_cnt", g_inst[0].wr_cnt, 2);
        check("t4_rd_cnt", g_inst[0].rd_cnt, 1);
        check("t4_cs_rise", g_inst[0].cs_rise, 3);
        check("t4_polls", 32'(rsp_polls[0]), 1);
        accept(0);
        repeat (3) step();
        check("t4_idle_after", 32'(busy[0]), 0);
        check("t4_cs_rise_after", g_inst[0].cs_rise, 3);

        // Reset pulsed in GAP abandons the command
        wait_cfg[0] = 4'd0;
        stray_en[0] = 1'b0;
        clear_mon();
        issue(0, 32'h4000_0000, 32'hCAFE_F00D);
        repeat (4) step();
        check("t6_busy_before", 32'(busy[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cs", 32'(cs[0]), 0);
        check("t6_busy", 32'(busy[0]), 0);
        check("t6_cmd_ready", 32'(cmd_ready[0]), 1);
        check("t6_rsp_valid", 32'(rsp_valid[0]), 0);
        bad = 0;
        repeat (15) begin
            step();
            if (rsp_valid[0] !== 1'b0 || cs[0] !== 1'b0) bad++;
        end
        check("t6_quiet", bad, 0);
        clear_mon();
        issue(0, 32'h4000_0000, 32'h1111_2222);
        wait_rsp(0, cyc);
        check("t6_rsp_cycle", cyc, 10);
        check("t6_status", 32'(rsp_status[0]), 0);
        check("t6_polls", 32'(rsp_polls[0]), 1);
        check("t6_wr0_data", g_inst[0].wr_data[0], 32'h1111_2222);
        accept(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
